// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared widths, constants and helpers for the register file
package regfile_sb_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  typedef logic [RegBus-1:0]     word_t;
  typedef logic [RegAddrBus-1:0] raddr_t;

  localparam word_t  ZeroWord    = '0;
  localparam raddr_t NOPRegAddr  = '0;
  localparam logic   WriteEnable = 1'b1;
  localparam logic   ReadEnable  = 1'b1;
  localparam logic   RstEnable   = 1'b1;

  // True when the write-back in this cycle targets the register being read.
  function automatic logic wb_hit(input logic we, input raddr_t waddr, input raddr_t raddr);
    return (we == WriteEnable) && (waddr == raddr);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - write-back, decode read and load-issue bus of the register file
interface regfile_sb_if;
  import regfile_sb_pkg::*;

  logic   we;
  raddr_t waddr;
  word_t  wdata;
  logic   re1;
  raddr_t raddr1;
  word_t  rdata1;
  logic   re2;
  raddr_t raddr2;
  word_t  rdata2;
  logic   iss_load;
  raddr_t iss_wd;
  logic   flush;
  logic   stallreq;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, iss_load, iss_wd, flush,
    input  rdata1, rdata2, stallreq
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, iss_load, iss_wd, flush,
    output rdata1, rdata2, stallreq
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// rtl/regfile_sb_scoreboard.sv - load-pending bitmap and decode stall request
module reg_scoreboard
  import regfile_sb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   we_i,
  input  raddr_t waddr_i,
  input  logic   re1_i,
  input  raddr_t raddr1_i,
  input  logic   re2_i,
  input  raddr_t raddr2_i,
  input  logic   iss_load_i,
  input  raddr_t iss_wd_i,
  input  logic   flush_i,
  output logic   stallreq_o
);

  logic [RegNum-1:0] pending_q, pending_d;
  logic              stall1, stall2;

  // Clear before set: a load issued on the write-back edge owns the register again.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (we_i == WriteEnable) pending_d[waddr_i] = 1'b0;
      if (iss_load_i && (iss_wd_i != NOPRegAddr)) pending_d[iss_wd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    stall1 = (re1_i == ReadEnable) && (raddr1_i != NOPRegAddr) && pending_q[raddr1_i]
             && !wb_hit(we_i, waddr_i, raddr1_i);
    stall2 = (re2_i == ReadEnable) && (raddr2_i != NOPRegAddr) && pending_q[raddr2_i]
             && !wb_hit(we_i, waddr_i, raddr2_i);
    stallreq_o = (rst != RstEnable) && (stall1 || stall2);
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 32x32 register file with write-back bypass and load-use scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  word_t regs_q [RegNum];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RegNum; i++) regs_q[i] <= ZeroWord;
    end else if ((bus.we == WriteEnable) && (bus.waddr != NOPRegAddr)) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    bus.rdata1 = ZeroWord;
    if (rst == RstEnable || bus.re1 != ReadEnable || bus.raddr1 == NOPRegAddr) begin
      bus.rdata1 = ZeroWord;
    end else if (wb_hit(bus.we, bus.waddr, bus.raddr1)) begin
      bus.rdata1 = bus.wdata;
    end else begin
      bus.rdata1 = regs_q[bus.raddr1];
    end
  end

  always_comb begin
    bus.rdata2 = ZeroWord;
    if (rst == RstEnable || bus.re2 != ReadEnable || bus.raddr2 == NOPRegAddr) begin
      bus.rdata2 = ZeroWord;
    end else if (wb_hit(bus.we, bus.waddr, bus.raddr2)) begin
      bus.rdata2 = bus.wdata;
    end else begin
      bus.rdata2 = regs_q[bus.raddr2];
    end
  end

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .we_i       (bus.we),
    .waddr_i    (bus.waddr),
    .re1_i      (bus.re1),
    .raddr1_i   (bus.raddr1),
    .re2_i      (bus.re2),
    .raddr2_i   (bus.raddr2),
    .iss_load_i (bus.iss_load),
    .iss_wd_i   (bus.iss_wd),
    .flush_i    (bus.flush),
    .stallreq_o (bus.stallreq)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard-driven testbench for regfile_sb
module tb_regfile_sb;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        st;
    string       name;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_failed = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  regfile_sb_if u_if ();

  regfile_sb u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic re1, input logic [4:0] raddr1,
                       input logic re2, input logic [4:0] raddr2,
                       input logic iss, input logic [4:0] iss_wd, input logic flush);
    u_if.we = we; u_if.waddr = waddr; u_if.wdata = wdata;
    u_if.re1 = re1; u_if.raddr1 = raddr1;
    u_if.re2 = re2; u_if.raddr2 = raddr2;
    u_if.iss_load = iss; u_if.iss_wd = iss_wd; u_if.flush = flush;
  endtask

  task automatic step(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                      input logic re1, input logic [4:0] raddr1,
                      input logic re2, input logic [4:0] raddr2,
                      input logic iss, input logic [4:0] iss_wd, input logic flush);
    @(negedge clk);
    drive(we, waddr, wdata, re1, raddr1, re2, raddr2, iss, iss_wd, flush);
  endtask

  task automatic expect_now(input logic [31:0] r1, input logic [31:0] r2, input logic st,
                            input string name);
    exp_q.push_back('{r1, r2, st, name});
    #1;
    obs_q.push_back('{u_if.rdata1, u_if.rdata2, u_if.stallreq, name});
  endtask

  task automatic test_reset;
    obs_t e, o;
    drive(0, 0, 0, 1, 5, 1, 5, 0, 0, 0);
    expect_now(0, 0, 0, "reset_state");
    @(negedge clk); rst = 1'b0;
    step(1, 5, 32'hDEADBEEF, 1, 5, 0, 0, 0, 0, 0);
    expect_now(32'hDEADBEEF, 0, 0, "r5_bypass");
    step(0, 0, 0, 1, 5, 1, 5, 0, 0, 0);
    expect_now(32'hDEADBEEF, 32'hDEADBEEF, 0, "r5_stored");
    #1 rst = 1'b1;
    expect_now(0, 0, 0, "r5_async_reset");
    @(negedge clk); rst = 1'b0;
    expect_now(0, 0, 0, "r5_after_release");
    step(1, 0, 32'h12345678, 1, 0, 0, 0, 0, 0, 0);
    expect_now(0, 0, 0, "r0_write_same_cycle");
    step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    expect_now(0, 0, 0, "r0_write_after");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if ({o.r1, o.r2, o.st} !== {e.r1, e.r2, e.st}) begin
        n_failed++;
        $display("FAIL %s: got r1=%h r2=%h st=%b, exp r1=%h r2=%h st=%b", e.name, o.r1, o.r2, o.st, e.r1, e.r2, e.st);
      end
    end
  endtask

  task automatic test_bypass;
    obs_t e, o;
    step(1, 7, 32'hA5A5A5A5, 1, 7, 1, 7, 0, 0, 0);
    expect_now(32'hA5A5A5A5, 32'hA5A5A5A5, 0, "bypass_same_cycle");
    step(0, 0, 0, 1, 7, 1, 7, 0, 0, 0);
    expect_now(32'hA5A5A5A5, 32'hA5A5A5A5, 0, "bypass_next_cycle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if ({o.r1, o.r2, o.st} !== {e.r1, e.r2, e.st}) begin
        n_failed++;
        $display("FAIL %s: got r1=%h r2=%h st=%b, exp r1=%h r2=%h st=%b", e.name, o.r1, o.r2, o.st, e.r1, e.r2, e.st);
      end
    end
  endtask

  task automatic test_load_use;
    obs_t e, o;
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    expect_now(0, 0, 0, "load_issue_cycle");
    step(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    expect_now(0, 0, 1, "load_use_stall");
    step(1, 9, 32'h55, 1, 9, 0, 0, 0, 0, 0);
    expect_now(32'h55, 0, 0, "load_wb_bypass");
    step(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    expect_now(32'h55, 0, 0, "load_after_wb");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if ({o.r1, o.r2, o.st} !== {e.r1, e.r2, e.st}) begin
        n_failed++;
        $display("FAIL %s: got r1=%h r2=%h st=%b, exp r1=%h r2=%h st=%b", e.name, o.r1, o.r2, o.st, e.r1, e.r2, e.st);
      end
    end
  endtask

  task automatic test_collision;
    obs_t e, o;
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    expect_now(0, 0, 0, "coll_issue");
    step(1, 3, 32'h33, 1, 3, 0, 0, 1, 3, 0);
    expect_now(32'h33, 0, 0, "coll_same_edge");
    step(0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    expect_now(32'h33, 0, 1, "coll_set_wins");
    step(1, 3, 32'h34, 0, 0, 1, 3, 0, 0, 0);
    expect_now(0, 32'h34, 0, "coll_wb");
    step(0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    expect_now(0, 32'h34, 0, "coll_cleared");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if ({o.r1, o.r2, o.st} !== {e.r1, e.r2, e.st}) begin
        n_failed++;
        $display("FAIL %s: got r1=%h r2=%h st=%b, exp r1=%h r2=%h st=%b", e.name, o.r1, o.r2, o.st, e.r1, e.r2, e.st);
      end
    end
  endtask

  task automatic test_flush;
    obs_t e, o;
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    step(1, 10, 32'h1010, 1, 4, 0, 0, 1, 8, 1);
    expect_now(0, 0, 1, "flush_cycle_pending");
    step(0, 0, 0, 1, 4, 1, 6, 0, 0, 0);
    expect_now(0, 0, 0, "flush_r4_r6");
    step(0, 0, 0, 1, 8, 1, 10, 0, 0, 0);
    expect_now(0, 32'h1010, 0, "flush_r8_and_write");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if ({o.r1, o.r2, o.st} !== {e.r1, e.r2, e.st}) begin
        n_failed++;
        $display("FAIL %s: got r1=%h r2=%h st=%b, exp r1=%h r2=%h st=%b", e.name, o.r1, o.r2, o.st, e.r1, e.r2, e.st);
      end
    end
  endtask

  task automatic test_disabled_read;
    obs_t e, o;
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    expect_now(0, 0, 0, "disabled_re2");
    step(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    expect_now(0, 0, 1, "enabled_re2_stall");
    step(1, 2, 32'h22, 0, 0, 1, 2, 1, 12, 0);
    expect_now(0, 32'h22, 0, "r2_wb");
    step(0, 0, 0, 1, 12, 1, 12, 0, 0, 0);
    expect_now(0, 0, 1, "both_ports_same_pending");
    step(1, 12, 32'hC0C0, 1, 12, 1, 12, 0, 0, 0);
    expect_now(32'hC0C0, 32'hC0C0, 0, "both_ports_wb");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if ({o.r1, o.r2, o.st} !== {e.r1, e.r2, e.st}) begin
        n_failed++;
        $display("FAIL %s: got r1=%h r2=%h st=%b, exp r1=%h r2=%h st=%b", e.name, o.r1, o.r2, o.st, e.r1, e.r2, e.st);
      end
    end
  endtask

  task automatic test_back_to_back;
    obs_t e, o;
    logic [31:0] v1, v2;
    for (int i = 1; i < 32; i++) begin
      step(1, 5'(i), 32'(i) * 32'h01010101 ^ 32'h5A000000, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 32; i++) begin
      v1 = (i == 0) ? 32'h0 : (32'(i) * 32'h01010101 ^ 32'h5A000000);
      v2 = (i == 0) ? 32'h0 : (32'(32 - i) * 32'h01010101 ^ 32'h5A000000);
      step(0, 0, 0, 1, 5'(i), 1, 5'(32 - i), 0, 0, 0);
      expect_now(v1, v2, 0, $sformatf("b2b_read_%0d", i));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if ({o.r1, o.r2, o.st} !== {e.r1, e.r2, e.st}) begin
        n_failed++;
        $display("FAIL %s: got r1=%h r2=%h st=%b, exp r1=%h r2=%h st=%b", e.name, o.r1, o.r2, o.st, e.r1, e.r2, e.st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_collision();
    test_flush();
    test_disabled_read();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
